next_pc_unit: RTL

//   Parametrised next-PC stage for the pipelined CPU: owns the PC register and selects among

---
 rtl/npc_if.sv | 17 +
 rtl/next_pc_unit.sv | 58 +++++
 2 files changed

// File: rtl/npc_if.sv
// npc_if: redirect/target inputs and PC/status outputs of the next-PC stage
interface npc_if #(parameter int WIDTH = 32);
    logic             stall;
    logic [2:0]       pcsrc;
    logic [WIDTH-1:0] btarget;
    logic [WIDTH-1:0] jtarget;
    logic [WIDTH-1:0] jrtarget;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pcadd4;
    logic             redirect;
    logic             pend;
    logic             alignerr;
    modport master (output stall, pcsrc, btarget, jtarget, jrtarget,
                    input pc, pcadd4, redirect, pend, alignerr);
    modport slave (input stall, pcsrc, btarget, jtarget, jrtarget,
                   output pc, pcadd4, redirect, pend, alignerr);
endinterface

// File: rtl/next_pc_unit.sv
// next_pc_unit: PC register with seq/branch/jump/jr select and stall-deferred redirect
// Define NPC_ALIGN_CHK_EN to force loaded targets word-aligned and flag alignerr.
module next_pc_unit #(
    parameter int          WIDTH    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input logic clk,
    input logic clrn,
    npc_if.slave bus
);
    logic [WIDTH-1:0] pc, pend_tgt, sel_tgt, load_tgt, fixed_tgt;
    logic             pend, redirect, align_err, req, misalign;
    always_comb begin
        sel_tgt  = (bus.pcsrc == 3'b001) ? bus.btarget :
                   (bus.pcsrc[2:1] == 2'b01) ? bus.jtarget : bus.jrtarget;
        req      = (bus.pcsrc != 3'b000) && (bus.pcsrc[2:1] != 2'b11);
        load_tgt = pend ? pend_tgt : sel_tgt;
`ifdef NPC_ALIGN_CHK_EN
        fixed_tgt = {load_tgt[WIDTH-1:2], 2'b00};
        misalign  = |load_tgt[1:0];
`else
        fixed_tgt = load_tgt;
        misalign  = 1'b0;
`endif
    end
    // Only the first redirect seen during a stall is kept; pending beats a fresh request.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pc        <= WIDTH'(RESET_PC);
            pend      <= 1'b0;
            pend_tgt  <= '0;
            redirect  <= 1'b0;
            align_err <= 1'b0;
        end else if (bus.stall) begin
            if (!pend && req) begin
                pend_tgt <= sel_tgt;
                pend     <= 1'b1;
            end
            redirect  <= 1'b0;
            align_err <= 1'b0;
        end else if (pend || req) begin
            pc        <= fixed_tgt;
            pend      <= 1'b0;
            redirect  <= 1'b1;
            align_err <= misalign;
        end else begin
            pc        <= bus.pcadd4;
            redirect  <= 1'b0;
            align_err <= 1'b0;
        end
    end
    assign bus.pc       = pc;
    assign bus.pcadd4   = pc + WIDTH'(PC_STEP);
    assign bus.redirect = redirect;
    assign bus.pend     = pend;
    assign bus.alignerr = align_err;
endmodule
